// File: rtl/textmode_pkg.sv
// Shared text-mode geometry, bus widths and cursor placement.
package textmode_pkg;

  localparam int unsigned COLS_DEF     = 80;
  localparam int unsigned ROWS_DEF     = 30;
  localparam int unsigned GLYPH_H_DEF  = 16;

  localparam int unsigned TEXT_AW      = 12;
  localparam int unsigned FONT_AW      = 12;
  localparam int unsigned CHAR_W       = 8;
  localparam int unsigned COL_W        = 7;
  localparam int unsigned ROW_W        = 5;
  localparam int unsigned GROW_W       = 4;
  localparam int unsigned PX_W         = 3;
  localparam int unsigned BLINK_W      = 6;

  // Underline cursor occupies the bottom CURSOR_LINES glyph rows of a cell
  localparam int unsigned CURSOR_LINES = 2;

  // First glyph row at which the cursor is drawn for a given glyph height
  function automatic logic [GROW_W-1:0] cursor_threshold(input int unsigned glyph_h);
    return GROW_W'(glyph_h - CURSOR_LINES);
  endfunction

endpackage

// File: rtl/text_renderer_if.sv
// Video timing, memory read ports, cursor control and pixel output of the renderer.
interface text_renderer_if;
  import textmode_pkg::*;

  logic                 frame_start;
  logic                 line_start;
  logic                 active;
  logic [TEXT_AW-1:0]   text_addr;
  logic [CHAR_W-1:0]    text_data;
  logic [FONT_AW-1:0]   font_addr;
  logic [CHAR_W-1:0]    font_data;
  logic                 cursor_en;
  logic [COL_W-1:0]     cursor_col;
  logic [ROW_W-1:0]     cursor_row;
  logic                 pixel;
  logic                 pixel_de;

  // Timing generator / memory side
  modport master (
    output frame_start, line_start, active, text_data, font_data,
           cursor_en, cursor_col, cursor_row,
    input  text_addr, font_addr, pixel, pixel_de
  );

  // Renderer side
  modport slave (
    input  frame_start, line_start, active, text_data, font_data,
           cursor_en, cursor_col, cursor_row,
    output text_addr, font_addr, pixel, pixel_de
  );

endinterface

// File: rtl/glyph_shifter.sv
// 8-bit glyph shift register with pixel-in-cell counter.
// At px==0 the incoming glyph's MSB is presented directly while it is loaded.
module glyph_shifter
  import textmode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              adv_i,
  input  logic [CHAR_W-1:0] glyph_i,
  output logic [PX_W-1:0]   px_o,
  output logic              bit_c_o
);

  logic [CHAR_W-1:0] shift_q, shift_d;
  logic [PX_W-1:0]   px_q, px_d;

  // Next-state: clear on new line, load/shift and count on each advancing pixel
  always_comb begin
    shift_d = shift_q;
    px_d    = px_q;
    if (clear_i) begin
      px_d = '0;
    end else if (adv_i) begin
      px_d = px_q + PX_W'(1);
      if (px_q == '0) begin
        shift_d = {glyph_i[CHAR_W-2:0], 1'b0};
      end else begin
        shift_d = {shift_q[CHAR_W-2:0], 1'b0};
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      px_q    <= '0;
    end else begin
      shift_q <= shift_d;
      px_q    <= px_d;
    end
  end

  assign px_o    = px_q;
  assign bit_c_o = (px_q == '0) ? glyph_i[CHAR_W-1] : shift_q[CHAR_W-1];

endmodule

// File: rtl/text_renderer.sv
// Character-cell text renderer: walks text RAM and font ROM with a 3-stage
// prefetch one cell ahead of the beam and serialises glyph bits to pixels.
module text_renderer
  import textmode_pkg::*;
#(
  parameter int unsigned COLS    = COLS_DEF,
  parameter int unsigned ROWS    = ROWS_DEF,
  parameter int unsigned GLYPH_H = GLYPH_H_DEF
) (
  input  logic           clk,
  input  logic           rst,
  text_renderer_if.slave bus
);

  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [GROW_W-1:0] LAST_GROW  = GROW_W'(GLYPH_H - 1);
  localparam logic [GROW_W-1:0] CURSOR_MIN = cursor_threshold(GLYPH_H);

  logic                 first_line_q, first_line_d;
  logic                 line_valid_q, line_valid_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic [GROW_W-1:0]    glyph_row_q, glyph_row_d;
  logic [ROW_W-1:0]     text_row_q, text_row_d;
  logic [TEXT_AW-1:0]   row_base_q, row_base_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [TEXT_AW-1:0]   text_addr_q, text_addr_d;
  logic [FONT_AW-1:0]   font_addr_q, font_addr_d;
  logic                 fetch_text_q, fetch_text_d;
  logic                 fetch_font_q, fetch_font_d;
  logic [CHAR_W-1:0]    next_glyph_q, next_glyph_d;
  logic                 pixel_q, pixel_d;
  logic                 pixel_de_q, pixel_de_d;

  logic                 adv_c;
  logic                 cursor_hit_c;
  logic                 glyph_bit_c;
  logic [PX_W-1:0]      px;

  // A pixel advances only inside a started line; line_start wins over active
  assign adv_c = bus.active & line_valid_q & ~bus.line_start;

  assign cursor_hit_c = bus.cursor_en & blink_q[BLINK_W-1] &
                        (glyph_row_q >= CURSOR_MIN) &
                        (text_row_q == bus.cursor_row) &
                        (col_q == bus.cursor_col);

  glyph_shifter u_shifter (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bus.line_start),
    .adv_i   (adv_c),
    .glyph_i (next_glyph_q),
    .px_o    (px),
    .bit_c_o (glyph_bit_c)
  );

  // Frame/line bookkeeping, prefetch pipeline and pixel output next-state
  always_comb begin
    first_line_d = first_line_q;
    line_valid_d = line_valid_q;
    blink_d      = blink_q;
    glyph_row_d  = glyph_row_q;
    text_row_d   = text_row_q;
    row_base_d   = row_base_q;
    col_d        = col_q;
    text_addr_d  = text_addr_q;
    fetch_text_d = 1'b0;
    fetch_font_d = fetch_text_q;
    font_addr_d  = font_addr_q;
    next_glyph_d = next_glyph_q;

    if (bus.frame_start) begin
      first_line_d = 1'b1;
      blink_d      = blink_q + BLINK_W'(1);
    end

    if (bus.line_start) begin
      // A coincident frame_start counts as already applied
      line_valid_d = 1'b1;
      col_d        = '0;
      if (first_line_q | bus.frame_start) begin
        first_line_d = 1'b0;
        glyph_row_d  = '0;
        text_row_d   = '0;
        row_base_d   = '0;
      end else if (glyph_row_q == LAST_GROW) begin
        glyph_row_d = '0;
        if (text_row_q == LAST_ROW) begin
          text_row_d = '0;
          row_base_d = '0;
        end else begin
          text_row_d = text_row_q + ROW_W'(1);
          row_base_d = row_base_q + TEXT_AW'(COLS);
        end
      end else begin
        glyph_row_d = glyph_row_q + GROW_W'(1);
      end
      text_addr_d  = row_base_d;
      fetch_text_d = 1'b1;
    end else if (adv_c) begin
      // Fetch the next cell on its neighbour's first pixel; none past the last column
      if ((px == '0) && (col_q < LAST_COL)) begin
        text_addr_d  = row_base_q + TEXT_AW'(col_q) + TEXT_AW'(1);
        fetch_text_d = 1'b1;
      end
      if (px == PX_W'(7)) begin
        col_d = col_q + COL_W'(1);
      end
    end

    if (fetch_text_q) begin
      font_addr_d = FONT_AW'({bus.text_data, glyph_row_q});
    end
    if (fetch_font_q) begin
      next_glyph_d = bus.font_data;
    end

    pixel_de_d = bus.active & line_valid_q;
    pixel_d    = adv_c & (glyph_bit_c | cursor_hit_c);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_line_q <= 1'b1;
      line_valid_q <= 1'b0;
      blink_q      <= '0;
      glyph_row_q  <= '0;
      text_row_q   <= '0;
      row_base_q   <= '0;
      col_q        <= '0;
      text_addr_q  <= '0;
      font_addr_q  <= '0;
      fetch_text_q <= 1'b0;
      fetch_font_q <= 1'b0;
      next_glyph_q <= '0;
      pixel_q      <= 1'b0;
      pixel_de_q   <= 1'b0;
    end else begin
      first_line_q <= first_line_d;
      line_valid_q <= line_valid_d;
      blink_q      <= blink_d;
      glyph_row_q  <= glyph_row_d;
      text_row_q   <= text_row_d;
      row_base_q   <= row_base_d;
      col_q        <= col_d;
      text_addr_q  <= text_addr_d;
      font_addr_q  <= font_addr_d;
      fetch_text_q <= fetch_text_d;
      fetch_font_q <= fetch_font_d;
      next_glyph_q <= next_glyph_d;
      pixel_q      <= pixel_d;
      pixel_de_q   <= pixel_de_d;
    end
  end

  assign bus.text_addr = text_addr_q;
  assign bus.font_addr = font_addr_q;
  assign bus.pixel     = pixel_q;
  assign bus.pixel_de  = pixel_de_q;

endmodule

// File: doc/text_renderer.md
TEXT_RENDERER -- requirements
Module: text_renderer

Interface
REQ-001 SHALL have parameters: COLS, default 80, text columns; ROWS, default 30, text rows; GLYPH_H, default 16, glyph lines per text row.
REQ-002 SHALL have port clk, input, 1, the single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port frame_start, input, 1, one-cycle pulse before the first line of a frame.
REQ-005 SHALL have port line_start, input, 1, one-cycle pulse at least 3 cycles before a line's first active pixel.
REQ-006 SHALL have port active, input, 1, pixel display enable, one cycle per pixel.
REQ-007 SHALL have ports text_addr (output, 12) and text_data (input, 8): text RAM read port; data is valid 1 cycle after the address.
REQ-008 SHALL have ports font_addr (output, 12) and font_data (input, 8): fontrom read port; data is valid 1 cycle after the address; MSB is the leftmost pixel.
REQ-009 SHALL have ports cursor_en (input, 1), cursor_col (input, 7) and cursor_row (input, 5): hardware cursor control.
REQ-010 SHALL have outputs pixel (1) and pixel_de (1): the registered pixel and its enable.

Function
REQ-011 SHALL form text_addr = row_base + col, with row_base maintained incrementally by adding COLS; no multiplier.
REQ-012 SHALL form font_addr = {text_data[7:0], glyph_row[3:0]}.
REQ-013 SHALL on frame_start set a first_line flag and advance the blink counter.
REQ-014 SHALL on line_start with first_line set: glyph_row=0, text_row=0, row_base=0, and clear first_line.
REQ-015 SHALL on line_start with first_line clear: increment glyph_row.
REQ-016 SHALL on glyph_row wrap GLYPH_H-1 -> 0: increment text_row and add COLS to row_base.
REQ-017 SHALL on text_row wrap ROWS-1 -> 0: set row_base to 0.
REQ-018 SHALL on every line_start reset col=0 and px=0, then start a prefetch of cell 0.
REQ-019 SHALL run a 3-stage prefetch: cycle F text_addr issued, F+1 font_addr issued, F+2 font_data captured into next_glyph.
REQ-020 SHALL on an active cycle with px==0: load next_glyph into the shifter and start the prefetch of cell col+1.
REQ-021 SHALL on every active cycle advance px (mod 8) and increment col when px wraps 7 -> 0.
REQ-022 SHALL issue no prefetch when col+1 == COLS; text_addr SHALL then hold its last value.
REQ-023 SHALL drive pixel_de = active delayed 1 cycle.
REQ-024 SHALL drive pixel = glyph bit (7-px) of the current cell, delayed 1 cycle, and 0 whenever pixel_de is 0.
REQ-025 SHALL force pixel=1 on the cursor cell when cursor_en=1, blink[5]=1, glyph_row >= GLYPH_H-2, text_row==cursor_row and col==cursor_col.
REQ-026 SHALL treat active deasserting mid-cell as a freeze: px and col hold, pixel=0.
REQ-027 SHALL give line_start priority over active when both are asserted in the same cycle.
REQ-028 SHALL, when frame_start and line_start coincide, apply frame_start first, so that line becomes line 0.

Reset
REQ-029 SHALL on rst asynchronously clear: pixel, pixel_de, text_addr, font_addr, col, px, glyph_row, text_row, row_base, next_glyph, shifter and blink.
REQ-030 SHALL set first_line=1 on reset.
REQ-031 SHALL abort a line in progress when rst is asserted; after release it outputs nothing until a line_start.

Structure
REQ-032 SHALL place COLS/ROWS/GLYPH_H defaults, address widths and the cursor glyph-row threshold in shared package textmode_pkg.
REQ-033 SHALL contain one sub-module, glyph_shifter: 8-bit load/shift register with a px counter.
REQ-034 SHALL instantiate neither the fontrom nor the text RAM; the top level wires both.

Verification
REQ-035 Model text RAM cell0=0x41 and fontrom(0x410)=0xA5, then line_start and active after 3 cycles -> font_addr=0x410 seen; pixel_de rises 1 cycle after active; pixel=1,0,1,0,0,1,0,1.
REQ-036 Drive frame_start then 17 line_starts -> 17th line issues text_addr 80 and font_addr low nibble 0.
REQ-037 Drive 480 lines then frame_start and line_start -> text_addr returns to 0; line 479 prefetches start at row_base 2320.
REQ-038 Run a full 640-pixel line -> exactly 80 text reads (0..79 + row_base); no read of col 80; pixel=0 after active falls.
REQ-039 Drop active for 5 cycles at px=3, then resume -> pixel stream continues at bit 4 with no skipped or repeated pixel.
REQ-040 Set cursor_en=1, cursor (col 2, row 0), blink[5]=1, glyph_row 14 -> pixels 16..23 are all 1; rst asserted mid-line drops pixel and pixel_de to 0 within the same cycle.
